// File: rtl/branch_ctrl_if.sv
// Bundle of the branch-resolution signals exchanged between the EX stage and branch_ctrl.
// The master modport is the pipeline side and the slave modport is the controller side.
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_br_valid;
  logic [2:0]       i_funct3;
  logic             i_br_eq;
  logic             i_br_lt;
  logic             i_stall;
  logic             i_cnt_clr;
  logic             o_br_un;
  logic             o_pc_sel;
  logic             o_flush_if;
  logic             o_flush_id;
  logic             o_busy;
  logic             o_illegal;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_taken_cnt;

  modport master (
    output i_br_valid, i_funct3, i_br_eq, i_br_lt, i_stall, i_cnt_clr,
    input  o_br_un, o_pc_sel, o_flush_if, o_flush_id, o_busy, o_illegal,
           o_br_cnt, o_taken_cnt
  );

  modport slave (
    input  i_br_valid, i_funct3, i_br_eq, i_br_lt, i_stall, i_cnt_clr,
    output o_br_un, o_pc_sel, o_flush_if, o_flush_id, o_busy, o_illegal,
           o_br_cnt, o_taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// Conditional-branch controller: decodes taken/not-taken in EX, drives the PC redirect
// and a FLUSH_DEPTH-cycle front-end squash, and keeps saturating branch/taken counters.
module branch_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  branch_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_flush_cnt, w_flush_cnt_next;
  logic             r_pc_sel, w_pc_sel_next;
  logic             r_flush, w_flush_next;
  logic             r_busy, w_busy_next;
  logic             r_illegal, w_illegal_next;
  logic [CNT_W-1:0] r_br_cnt, r_taken_cnt;
  logic             w_taken, w_reserved, w_eval;

  assign bus.o_br_un     = (bus.i_funct3[2:1] == 2'b11);
  assign w_reserved      = (bus.i_funct3[2:1] == 2'b01);
  assign w_eval          = (r_state == IDLE) && bus.i_br_valid && !bus.i_stall;

  always_comb begin
    w_taken = 1'b0;
    case (bus.i_funct3)
      3'b000:         w_taken = bus.i_br_eq;
      3'b001:         w_taken = !bus.i_br_eq;
      3'b100, 3'b110: w_taken = bus.i_br_lt;
      3'b101, 3'b111: w_taken = !bus.i_br_lt;
      default:        w_taken = 1'b0;
    endcase
  end

  // Outputs are computed for the state being entered so that they appear registered.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_pc_sel_next    = 1'b0;
    w_flush_next     = 1'b0;
    w_busy_next      = 1'b0;
    w_illegal_next   = 1'b0;
    case (r_state)
      IDLE: begin
        w_illegal_next = w_eval && w_reserved;
        if (w_eval && w_taken) begin
          w_state_next  = REDIRECT;
          w_pc_sel_next = 1'b1;
          w_flush_next  = 1'b1;
          w_busy_next   = 1'b1;
        end
      end
      REDIRECT: begin
        if (FLUSH_DEPTH > 1) begin
          w_state_next     = FLUSH;
          w_flush_cnt_next = 3'(FLUSH_DEPTH - 1);
          w_flush_next     = 1'b1;
          w_busy_next      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      FLUSH: begin
        if (r_flush_cnt <= 3'd1) begin
          w_state_next     = IDLE;
          w_flush_cnt_next = 3'd0;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 3'd1;
          w_flush_next     = 1'b1;
          w_busy_next      = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= 3'd0;
      r_pc_sel    <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!bus.i_stall) begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_pc_sel    <= w_pc_sel_next;
      r_flush     <= w_flush_next;
      r_busy      <= w_busy_next;
      r_illegal   <= w_illegal_next;
    end
  end

  // Clear is checked before the stall gate (w_eval already excludes stalled cycles).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (bus.i_cnt_clr) begin
      r_br_cnt    <= '0;
      r_taken_cnt <= '0;
    end else if (w_eval) begin
      if (r_br_cnt != '1)
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_taken && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign bus.o_pc_sel    = r_pc_sel;
  assign bus.o_flush_if  = r_flush;
  assign bus.o_flush_id  = r_flush;
  assign bus.o_busy      = r_busy;
  assign bus.o_illegal   = r_illegal;
  assign bus.o_br_cnt    = r_br_cnt;
  assign bus.o_taken_cnt = r_taken_cnt;
endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: table of funct3/compare vectors plus hand-built stall, clear,
// saturation and reset sequences on a default instance and a FLUSH_DEPTH=1/CNT_W=4 one.
module tb_branch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(16)) bus_a ();
  branch_ctrl_if #(.CNT_W(4))  bus_b ();

  branch_ctrl #(.FLUSH_DEPTH(2), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  branch_ctrl #(.FLUSH_DEPTH(1), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  typedef struct {
    logic [2:0] f3;
    logic       eq;
    logic       lt;
    logic       exp_brun;
    logic       exp_taken;
    logic       exp_ill;
  } vec_t;

  typedef struct {
    logic pc_sel;
    logic illegal;
    logic flush;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_br  = 0;
  int   exp_tk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_cnts(input string name);
    check({name, "_br_cnt"},    32'(bus_a.o_br_cnt),    32'(exp_br));
    check({name, "_taken_cnt"}, 32'(bus_a.o_taken_cnt), 32'(exp_tk));
  endtask

  task automatic drive_a(input logic v, input logic [2:0] f3, input logic eq, input logic lt);
    bus_a.i_br_valid = v;
    bus_a.i_funct3   = f3;
    bus_a.i_br_eq    = eq;
    bus_a.i_br_lt    = lt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            f3      eq    lt    brun  taken ill
    vecs[0]  = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    drive_a(1'b0, 3'b000, 1'b0, 1'b0);
    bus_a.i_stall = 1'b0; bus_a.i_cnt_clr = 1'b0;
    bus_b.i_br_valid = 1'b0; bus_b.i_funct3 = 3'b000; bus_b.i_br_eq = 1'b0;
    bus_b.i_br_lt = 1'b0; bus_b.i_stall = 1'b0; bus_b.i_cnt_clr = 1'b0;
    #1;
    check("rst_pc_sel",   32'(bus_a.o_pc_sel),   32'd0);
    check("rst_flush_if", 32'(bus_a.o_flush_if), 32'd0);
    check("rst_busy",     32'(bus_a.o_busy),     32'd0);
    check("rst_illegal",  32'(bus_a.o_illegal),  32'd0);
    check_cnts("rst");
    check("rst_b_br_cnt", 32'(bus_b.o_br_cnt),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: one evaluation each, scoreboard holds the next-cycle expectation.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_a(1'b1, vecs[i].f3, vecs[i].eq, vecs[i].lt);
      #1 check("vec_br_un", 32'(bus_a.o_br_un), 32'(vecs[i].exp_brun));
      sb_q.push_back('{vecs[i].exp_taken, vecs[i].exp_ill, vecs[i].exp_taken});
      exp_br++;
      if (vecs[i].exp_taken) exp_tk++;
      @(negedge clk);
      bus_a.i_br_valid = 1'b0;
      e = sb_q.pop_front();
      check("vec_pc_sel",   32'(bus_a.o_pc_sel),   32'(e.pc_sel));
      check("vec_illegal",  32'(bus_a.o_illegal),  32'(e.illegal));
      check("vec_flush_if", 32'(bus_a.o_flush_if), 32'(e.flush));
      $display("[TB] vec %0d f3=%b eq=%b lt=%b pc_sel=%b illegal=%b", i, vecs[i].f3,
               vecs[i].eq, vecs[i].lt, bus_a.o_pc_sel, bus_a.o_illegal);
      @(negedge clk);
      if (vecs[i].exp_taken) begin
        check("vec_flush_pc_sel", 32'(bus_a.o_pc_sel),   32'd0);
        check("vec_flush_id",     32'(bus_a.o_flush_id), 32'd1);
        check("vec_flush_busy",   32'(bus_a.o_busy),     32'd1);
      end else begin
        check("vec_illegal_pulse", 32'(bus_a.o_illegal), 32'd0);
        check("vec_idle_busy",     32'(bus_a.o_busy),    32'd0);
      end
      @(negedge clk);
      check("vec_end_busy",  32'(bus_a.o_busy),     32'd0);
      check("vec_end_flush", 32'(bus_a.o_flush_if), 32'd0);
      check_cnts("vec");
    end

    // br_valid held through REDIRECT and FLUSH is not re-evaluated.
    @(negedge clk);
    drive_a(1'b1, 3'b000, 1'b1, 1'b0);
    exp_br++; exp_tk++;
    @(negedge clk);
    check("hold_redirect", 32'(bus_a.o_pc_sel), 32'd1);
    @(negedge clk);
    check("hold_flush_pc_sel", 32'(bus_a.o_pc_sel), 32'd0);
    @(negedge clk);
    bus_a.i_br_valid = 1'b0;
    check("hold_no_redirect", 32'(bus_a.o_pc_sel), 32'd0);
    check("hold_busy",        32'(bus_a.o_busy),   32'd0);
    check_cnts("hold");
    $display("[TB] held br_valid: br_cnt=%0d taken_cnt=%0d", bus_a.o_br_cnt, bus_a.o_taken_cnt);

    // A stalled IDLE cycle does not evaluate.
    @(negedge clk);
    drive_a(1'b1, 3'b000, 1'b1, 1'b0);
    bus_a.i_stall = 1'b1;
    @(negedge clk);
    drive_a(1'b0, 3'b000, 1'b0, 1'b0);
    bus_a.i_stall = 1'b0;
    check("stall_idle_pc_sel", 32'(bus_a.o_pc_sel), 32'd0);
    check_cnts("stall_idle");
    $display("[TB] stalled branch in IDLE: pc_sel=%b", bus_a.o_pc_sel);

    // Stall for three cycles once FLUSH is entered.
    @(negedge clk);
    drive_a(1'b1, 3'b000, 1'b1, 1'b0);
    exp_br++; exp_tk++;
    @(negedge clk);
    bus_a.i_br_valid = 1'b0;
    check("stall_redirect", 32'(bus_a.o_pc_sel), 32'd1);
    @(negedge clk);
    check("stall_enter_flush", 32'(bus_a.o_flush_if), 32'd1);
    bus_a.i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_flush_if", 32'(bus_a.o_flush_if), 32'd1);
      check("stall_busy",     32'(bus_a.o_busy),     32'd1);
    end
    bus_a.i_stall = 1'b0;
    @(negedge clk);
    check("stall_release_busy",  32'(bus_a.o_busy),     32'd0);
    check("stall_release_flush", 32'(bus_a.o_flush_if), 32'd0);
    check_cnts("stall_flush");
    $display("[TB] stall in FLUSH: busy=%b after release", bus_a.o_busy);

    // cnt_clr acts while stalled.
    @(negedge clk);
    bus_a.i_stall = 1'b1; bus_a.i_cnt_clr = 1'b1;
    @(negedge clk);
    bus_a.i_stall = 1'b0; bus_a.i_cnt_clr = 1'b0;
    exp_br = 0; exp_tk = 0;
    check_cnts("clr_stall");

    // cnt_clr beats a same-cycle taken branch, which still redirects.
    @(negedge clk);
    drive_a(1'b1, 3'b000, 1'b0, 1'b0);
    exp_br++;
    @(negedge clk);
    drive_a(1'b1, 3'b000, 1'b1, 1'b0);
    bus_a.i_cnt_clr = 1'b1;
    @(negedge clk);
    bus_a.i_br_valid = 1'b0; bus_a.i_cnt_clr = 1'b0;
    exp_br = 0; exp_tk = 0;
    check("clr_br_redirect", 32'(bus_a.o_pc_sel), 32'd1);
    check_cnts("clr_branch");
    $display("[TB] cnt_clr with branch: br_cnt=%0d", bus_a.o_br_cnt);
    repeat (2) @(negedge clk);

    // FLUSH_DEPTH=1: REDIRECT only, then straight back to IDLE.
    @(negedge clk);
    bus_b.i_br_valid = 1'b1; bus_b.i_funct3 = 3'b000; bus_b.i_br_eq = 1'b1;
    @(negedge clk);
    bus_b.i_br_valid = 1'b0;
    check("d1_pc_sel",   32'(bus_b.o_pc_sel),   32'd1);
    check("d1_flush_if", 32'(bus_b.o_flush_if), 32'd1);
    @(negedge clk);
    check("d1_no_flush", 32'(bus_b.o_flush_if), 32'd0);
    check("d1_busy",     32'(bus_b.o_busy),     32'd0);

    // 17 more taken branches on the 4-bit counters: both must hold at 15.
    bus_b.i_br_valid = 1'b1;
    repeat (34) @(negedge clk);
    bus_b.i_br_valid = 1'b0;
    check("sat_br_cnt",    32'(bus_b.o_br_cnt),    32'd15);
    check("sat_taken_cnt", 32'(bus_b.o_taken_cnt), 32'd15);
    $display("[TB] saturation: br_cnt=%0d taken_cnt=%0d", bus_b.o_br_cnt, bus_b.o_taken_cnt);
    @(negedge clk);

    // Asynchronous reset in the middle of REDIRECT.
    @(negedge clk);
    drive_a(1'b1, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    bus_a.i_br_valid = 1'b0;
    check("mid_redirect", 32'(bus_a.o_pc_sel), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc_sel",   32'(bus_a.o_pc_sel),   32'd0);
    check("arst_flush_if", 32'(bus_a.o_flush_if), 32'd0);
    check("arst_flush_id", 32'(bus_a.o_flush_id), 32'd0);
    check("arst_busy",     32'(bus_a.o_busy),     32'd0);
    exp_br = 0; exp_tk = 0;
    check_cnts("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_flush", 32'(bus_a.o_flush_if), 32'd0);
    check("post_rst_busy",  32'(bus_a.o_busy),     32'd0);
    check_cnts("post_rst");
    check("post_rst_b_cnt", 32'(bus_b.o_br_cnt),   32'd0);
    $display("[TB] reset during REDIRECT: busy=%b flush_if=%b", bus_a.o_busy, bus_a.o_flush_if);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2, number of cycles flush_if/flush_id are held after a taken branch; legal range 1..4.
REQ-002 Parameter CNT_W, default 16, width of the branch and taken performance counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 br_valid  input  1  conditional branch present in EX this cycle.
REQ-006 funct3  input  3  branch funct3 of the EX instruction.
REQ-007 BrEq  input  1  equality result from branch_comp.
REQ-008 BrLT  input  1  less-than result from branch_comp.
REQ-009 stall_in  input  1  pipeline stall; freezes this block.
REQ-010 cnt_clr  input  1  synchronous clear of both performance counters.
REQ-011 BrUn  output  1  unsigned-compare select driven to branch_comp.
REQ-012 PCSel  output  1  select branch target as next PC.
REQ-013 flush_if  output  1  squash the IF/ID register.
REQ-014 flush_id  output  1  squash the ID/EX register.
REQ-015 busy  output  1  redirect/flush sequence in progress.
REQ-016 illegal  output  1  one-cycle pulse on a reserved funct3.
REQ-017 br_cnt  output  CNT_W  evaluated branch count.
REQ-018 taken_cnt  output  CNT_W  taken branch count.

Function
REQ-019 BrUn SHALL be combinational: 1 when funct3 is 110 (BLTU) or 111 (BGEU), else 0, independent of br_valid.
REQ-020 Taken SHALL be decoded combinationally: 000 BrEq; 001 !BrEq; 100/110 BrLT; 101/111 !BrLT; 010/011 not taken.
REQ-021 The FSM SHALL have states IDLE, REDIRECT, FLUSH; the branch is evaluated only in IDLE with br_valid=1 and stall_in=0.
REQ-022 IDLE -> REDIRECT on an evaluated taken branch; otherwise remain in IDLE.
REQ-023 REDIRECT SHALL last exactly one cycle with PCSel=1, flush_if=1, flush_id=1, busy=1; the redirect therefore appears one cycle after evaluation.
REQ-024 REDIRECT -> FLUSH if FLUSH_DEPTH>1, else -> IDLE; FLUSH holds flush_if=1, flush_id=1, PCSel=0, busy=1 for FLUSH_DEPTH-1 cycles via a down-counter, then -> IDLE.
REQ-025 br_valid in REDIRECT or FLUSH SHALL be ignored: no evaluation, no count, no illegal pulse.
REQ-026 stall_in=1 SHALL freeze the state, flush counter, performance counters, and all registered outputs at their current values.
REQ-027 An evaluated reserved funct3 SHALL pulse illegal for one cycle on the next cycle and SHALL NOT redirect.
REQ-028 Each evaluated branch, including reserved funct3, SHALL increment br_cnt; each taken branch SHALL also increment taken_cnt.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.
REQ-030 cnt_clr SHALL zero both counters next cycle, win over a same-cycle increment, and act even while stall_in=1.
REQ-031 PCSel, flush_if, flush_id, busy, and illegal SHALL be registered outputs.

Reset
REQ-032 reset low SHALL immediately force IDLE, flush counter 0, PCSel=flush_if=flush_id=busy=illegal=0, and br_cnt=taken_cnt=0.
REQ-033 Reset asserted mid REDIRECT/FLUSH SHALL abort the sequence; the first cycle after release is IDLE with no residual flush.

Verification
REQ-034 BEQ: funct3=000, BrEq=1 -> next cycle PCSel=1 with both flushes; next cycle flushes only; then idle; br_cnt=1, taken_cnt=1.
REQ-035 BLTU: funct3=110, BrLT=0 -> BrUn=1 same cycle, no redirect; br_cnt=1, taken_cnt=0. BGE: funct3=101, BrLT=0 -> taken, BrUn=0.
REQ-036 Taken branch, then br_valid=1 held through REDIRECT/FLUSH -> counts stay 1/1, no second redirect.
REQ-037 stall_in=1 for 3 cycles entering FLUSH -> flush_if stays 1 for those 3 cycles plus the remaining count; busy drops only after that.
REQ-038 funct3=011 evaluated -> illegal=1 for one cycle, PCSel=0, br_cnt+1. CNT_W=4 with 17 taken branches -> both counts held at 15. cnt_clr with a same-cycle branch -> counts 0.
REQ-039 reset low during REDIRECT -> all outputs 0 at once; after release, IDLE and counters 0.
